// File: rtl/arbitro_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arbitro_pkg
//  Purpose  : Shared constants, state encoding and priority-scan helpers for
//             the 8-way round-robin arbiter.
//  Contents : N_REQ / IDX_W / CNT_W sizes, FSM state codes, rotate_right()
//             and first_set() helpers used by the arbitration chain.
//  Revision : 1.0 - initial release
// ============================================================================
package arbitro_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    // FSM state codes; 2'b11 is unused and recovers to IDLE.
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] GRANT = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;

    // Rotate v right by sh so that bit sh lands at position 0. After this,
    // the lowest set bit is the first requester at or after the pointer.
    function automatic logic [N_REQ-1:0] rotate_right(
        input logic [N_REQ-1:0] v,
        input logic [IDX_W-1:0] sh
    );
        logic [N_REQ-1:0] r;
        logic [IDX_W-1:0] j;
        r = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j    = IDX_W'(i) + sh;
            r[i] = v[j];
        end
        return r;
    endfunction

    // Index of the lowest set bit; 0 when v is all-zero (caller qualifies
    // the result with |v).
    function automatic logic [IDX_W-1:0] first_set(input logic [N_REQ-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage : arbitro_pkg
`default_nettype wire

// File: rtl/arbitro_rr8_dec.sv
`default_nettype none
// ============================================================================
//  Module   : Decoder_3para8
//  Purpose  : 3-to-8 one-hot decoder.
//  Ports    : i_sel    [2:0] binary index in
//             o_onehot [7:0] one-hot vector out (bit i_sel set)
//  Revision : 1.0 - initial release
// ============================================================================
module Decoder_3para8
    import arbitro_pkg::*;
(
    input  logic [IDX_W-1:0] i_sel,
    output logic [N_REQ-1:0] o_onehot
);

    for (genvar i = 0; i < N_REQ; i++) begin : g_dec
        assign o_onehot[i] = (i_sel == IDX_W'(i));
    end

endmodule : Decoder_3para8
`default_nettype wire

// File: rtl/arbitro_rr8.sv
`default_nettype none
// ============================================================================
//  Module   : arbitro_rr8
//  Purpose  : Round-robin arbiter for 8 requesters. Holds the grant while the
//             winner keeps requesting, forces release after MAX_HOLD cycles
//             when someone else is waiting, and inserts one dead (PAUSE)
//             cycle after every release for bus turnaround.
//  Ports    : clk       - clock, rising edge
//             reset     - asynchronous active-high reset
//             req[7:0]  - level requests, bit i = requester i
//             gnt[7:0]  - one-hot grant, zero when nobody is granted
//             gnt_idx   - index of the current/last winner
//             gnt_valid - high exactly when gnt is non-zero
//             timeout   - one-cycle pulse in the PAUSE after a forced release
//  Params   : MAX_HOLD  - max consecutive grant cycles with others pending
//                         (legal 2..15)
//  Revision : 1.0 - initial release
// ============================================================================
module arbitro_rr8
    import arbitro_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    logic [N_REQ-1:0] w_idx_oh;
    logic [N_REQ-1:0] w_rot;
    logic [IDX_W-1:0] w_offset;
    logic [IDX_W-1:0] w_winner;
    logic             w_any_req;
    logic             w_own_req;
    logic             w_others;
    logic             w_force;

    Decoder_3para8 u_dec (
        .i_sel    (r_idx),
        .o_onehot (w_idx_oh)
    );

    // Priority scan: rotate so ptr sits at bit 0, take the first set bit,
    // then add ptr back (3-bit wrap) to get the absolute winner.
    assign w_rot     = rotate_right(req, r_ptr);
    assign w_offset  = first_set(w_rot);
    assign w_winner  = r_ptr + w_offset;
    assign w_any_req = |req;

    // Winner's own request and whether anyone else is waiting.
    assign w_own_req = |(req & w_idx_oh);
    assign w_others  = |(req & ~w_idx_oh);

    // >= rather than == so a sole holder whose counter has saturated is
    // released on the first edge that sees a competing request.
    assign w_force   = (r_cnt >= c_HOLD_LAST) && w_others;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            // timeout is a single-cycle pulse unless re-set below.
            r_timeout <= 1'b0;
            case (r_state)
                IDLE, PAUSE: begin
                    if (w_any_req) begin
                        r_idx   <= w_winner;
                        r_cnt   <= '0;
                        r_state <= GRANT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                GRANT: begin
                    if (!w_own_req) begin
                        // Normal release wins over a coincident forced one.
                        r_state <= PAUSE;
                        r_ptr   <= r_idx + IDX_W'(1);
                    end else if (w_force) begin
                        r_state   <= PAUSE;
                        r_ptr     <= r_idx + IDX_W'(1);
                        r_timeout <= 1'b1;
                    end else if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt_valid = (r_state == GRANT);
    assign gnt       = w_idx_oh & {N_REQ{gnt_valid}};
    assign gnt_idx   = r_idx;
    assign timeout   = r_timeout;

endmodule : arbitro_rr8
`default_nettype wire

// File: tb/tb_arbitro_rr8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arbitro_rr8
//  Purpose  : Self-checking bench for arbitro_rr8 (MAX_HOLD = 4). Directed
//             scenarios plus randomized requests compared against a
//             behavioural owner/hold-length model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arbitro_rr8;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int nChecks = 0;
    int nPass   = 0;

    // Behavioural model: who owns the resource (-1 = nobody), how many
    // cycles it has held it, next priority start, last winner, timeout.
    int mOwner = -1;
    int mHeld  = 0;
    int mPtr   = 0;
    int mIdx   = 0;
    bit mTo    = 1'b0;

    arbitro_rr8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        mOwner = -1;
        mHeld  = 0;
        mPtr   = 0;
        mIdx   = 0;
        mTo    = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] r);
        bit found;
        int p;
        mTo = 1'b0;
        if (mOwner >= 0) begin
            if (!r[mOwner]) begin
                mPtr   = (mOwner + 1) % 8;
                mOwner = -1;
            end else if (mHeld >= MAX_HOLD && (r & ~(8'd1 << mOwner)) != 8'h00) begin
                mPtr   = (mOwner + 1) % 8;
                mOwner = -1;
                mTo    = 1'b1;
            end else begin
                mHeld++;
            end
        end else begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                p = (mPtr + k) % 8;
                if (!found && r[p]) begin
                    found  = 1'b1;
                    mOwner = p;
                    mIdx   = p;
                    mHeld  = 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_edge(req);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 8'h00;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req   = 8'hFF;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nChecks++; if (gnt !== 8'h00) $display("FAIL reset_gnt: got %h want 00", gnt); else nPass++;
        nChecks++; if (gnt_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", gnt_valid); else nPass++;
        nChecks++; if (gnt_idx !== 3'd0) $display("FAIL reset_idx: got %0d want 0", gnt_idx); else nPass++;
        nChecks++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout); else nPass++;
        // Release, get requester 5 granted, then reset mid-cycle.
        @(negedge clk);
        reset = 1'b0;
        req   = 8'h20;
        model_reset();
        tick();
        nChecks++; if (gnt !== 8'h20) $display("FAIL pre_async_gnt: got %h want 20", gnt); else nPass++;
        #3;
        reset = 1'b1;
        #1;
        nChecks++; if (gnt !== 8'h00) $display("FAIL async_reset_gnt: got %h want 00", gnt); else nPass++;
        nChecks++; if (gnt_valid !== 1'b0) $display("FAIL async_reset_valid: got %b want 0", gnt_valid); else nPass++;
        nChecks++; if (gnt_idx !== 3'd0) $display("FAIL async_reset_idx: got %0d want 0", gnt_idx); else nPass++;
        @(negedge clk);
        reset = 1'b0;
        req   = 8'h00;
        model_reset();
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h04;
        tick();
        nChecks++; if (gnt !== 8'h04 || gnt_idx !== 3'd2 || gnt_valid !== 1'b1)
            $display("FAIL single_grant: got gnt=%h idx=%0d v=%b want 04/2/1", gnt, gnt_idx, gnt_valid); else nPass++;
        @(negedge clk);
        req = 8'h00;
        tick();
        nChecks++; if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd2)
            $display("FAIL single_release: got gnt=%h v=%b idx=%0d want 00/0/2", gnt, gnt_valid, gnt_idx); else nPass++;
        tick();
        nChecks++; if (gnt !== 8'h00) $display("FAIL single_idle: got %h want 00", gnt); else nPass++;
        // ptr should now be 3: with everyone requesting, 3 wins.
        @(negedge clk);
        req = 8'hFF;
        tick();
        nChecks++; if (gnt !== 8'h08) $display("FAIL single_ptr3: got %h want 08", gnt); else nPass++;
        @(negedge clk);
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_rotation();
        logic [7:0] prev;
        int grants, held, cur;
        do_reset();
        req    = 8'hFF;
        prev   = 8'h00;
        grants = 0;
        held   = 0;
        cur    = 0;
        for (int cyc = 0; cyc < 200 && grants < 9; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                if (gnt != 8'h00) begin
                    held++;
                    if (held >= 2) req[gnt_idx] = 1'b0;
                end else begin
                    req  = 8'hFF;
                    held = 0;
                end
            end
            tick();
            if (gnt != 8'h00 && prev == 8'h00) begin
                cur = grants % 8;
                nChecks++; if (gnt !== (8'd1 << cur) || timeout !== 1'b0)
                    $display("FAIL rotation_%0d: got gnt=%h to=%b want %h/0", grants, gnt, timeout, 8'd1 << cur); else nPass++;
                grants++;
            end
            prev = gnt;
        end
        nChecks++; if (grants != 9) $display("FAIL rotation_count: got %0d grants want 9", grants); else nPass++;
        @(negedge clk);
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        req = 8'h40;
        tick();
        @(negedge clk);
        req = 8'h00;
        tick();
        tick();
        @(negedge clk);
        req = 8'h41;
        tick();
        nChecks++; if (gnt !== 8'h01 || gnt_idx !== 3'd0)
            $display("FAIL wrap_priority: got gnt=%h idx=%0d want 01/0", gnt, gnt_idx); else nPass++;
        @(negedge clk);
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_forced();
        logic [7:0] expG [11];
        logic       expT [11];
        expG = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h01};
        expT = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        req = 8'h03;
        for (int i = 0; i < 11; i++) begin
            tick();
            nChecks++; if (gnt !== expG[i] || timeout !== expT[i])
                $display("FAIL forced_cyc%0d: got gnt=%h to=%b want %h/%b", i, gnt, timeout, expG[i], expT[i]); else nPass++;
        end
        @(negedge clk);
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_sole();
        do_reset();
        req = 8'h10;
        for (int i = 0; i < 20; i++) begin
            tick();
            nChecks++; if (gnt !== 8'h10 || timeout !== 1'b0)
                $display("FAIL sole_hold_%0d: got gnt=%h to=%b want 10/0", i, gnt, timeout); else nPass++;
        end
        @(negedge clk);
        req = 8'h11;
        tick();
        nChecks++; if (gnt !== 8'h00 || timeout !== 1'b1)
            $display("FAIL sole_release: got gnt=%h to=%b want 00/1", gnt, timeout); else nPass++;
        tick();
        nChecks++; if (gnt !== 8'h01 || timeout !== 1'b0)
            $display("FAIL sole_next: got gnt=%h to=%b want 01/0", gnt, timeout); else nPass++;
        @(negedge clk);
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [7:0] expG;
        do_reset();
        req = 8'($urandom);
        for (int i = 0; i < 400; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            end
            tick();
            expG = (mOwner >= 0) ? (8'd1 << mOwner) : 8'h00;
            nChecks++;
            if (gnt !== expG || gnt_idx !== 3'(mIdx) || gnt_valid !== (mOwner >= 0) || timeout !== mTo)
                $display("FAIL random_%0d: got gnt=%h idx=%0d v=%b to=%b want %h/%0d/%b/%b",
                         i, gnt, gnt_idx, gnt_valid, timeout, expG, mIdx, (mOwner >= 0), mTo);
            else
                nPass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_forced();
        test_sole();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule : tb_arbitro_rr8
`default_nettype wire
